// File: rtl/pipeline_memory_pkg.sv
// rtl/pipeline_memory_pkg.sv - shared types and load-extension helpers for pipeline_memory_sb
package pipeline_memory_pkg;

  localparam int SB_ADDR_W = 64;
  localparam int SB_DATA_W = 64;

  typedef enum logic [6:0] {
    OP_NONE  = 7'd0,
    OP_LOAD  = 7'd1,
    OP_STORE = 7'd2,
    OP_ALU   = 7'd3
  } opcode_e;

  typedef enum logic [3:0] {
    SZ_B  = 4'd0,
    SZ_H  = 4'd1,
    SZ_W  = 4'd2,
    SZ_D  = 4'd3,
    SZ_BU = 4'd4,
    SZ_WU = 4'd5,
    SZ_HU = 4'd6
  } mem_size_e;

  typedef enum logic [1:0] {F_IDLE, F_LD_REQ, F_LD_RESP} front_state_e;
  typedef enum logic [1:0] {D_IDLE, D_REQ, D_WAIT} drain_state_e;

  typedef struct packed {
    logic [SB_ADDR_W-1:0] addr;
    logic [SB_DATA_W-1:0] data;
    logic [1:0]           size;
  } sb_entry_t;

  // Byte width code (0 B, 1 H, 2 W, 3 D) shared by stores and loads; unknown sizes act as D.
  function automatic logic [1:0] size_width(input logic [3:0] sz);
    case (sz)
      SZ_B, SZ_BU: size_width = 2'd0;
      SZ_H, SZ_HU: size_width = 2'd1;
      SZ_W, SZ_WU: size_width = 2'd2;
      default:     size_width = 2'd3;
    endcase
  endfunction

  function automatic logic [SB_DATA_W-1:0] extend_load(input logic [SB_DATA_W-1:0] raw,
                                                       input logic [3:0] sz);
    case (sz)
      SZ_B:    extend_load = {{56{raw[7]}}, raw[7:0]};
      SZ_BU:   extend_load = {56'd0, raw[7:0]};
      SZ_H:    extend_load = {{48{raw[15]}}, raw[15:0]};
      SZ_HU:   extend_load = {48'd0, raw[15:0]};
      SZ_W:    extend_load = {{32{raw[31]}}, raw[31:0]};
      SZ_WU:   extend_load = {32'd0, raw[31:0]};
      default: extend_load = raw;
    endcase
  endfunction

endpackage

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - circular store buffer with per-entry dword overlap compare
// Youngest-match outputs exist only when PIPELINE_MEMORY_SB_FWD_EN is defined.
module mem_store_buffer
  import pipeline_memory_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_push,
  input  sb_entry_t             i_push_entry,
  input  logic                  i_pop,
  input  logic [SB_ADDR_W-4:0]  i_chk_dword,
`ifdef PIPELINE_MEMORY_SB_FWD_EN
  output logic                  o_young_hit,
  output sb_entry_t             o_young_entry,
`endif
  output sb_entry_t             o_head,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [SB_DEPTH-1:0]   o_overlap
);

  localparam int PW = $clog2(SB_DEPTH);

  sb_entry_t           r_mem [SB_DEPTH];
  logic [SB_DEPTH-1:0] r_valid;
  logic [PW-1:0]       r_wr_ptr;
  logic [PW-1:0]       r_rd_ptr;
  logic [PW:0]         r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_valid  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr_ptr] <= i_push_entry;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == (PW+1)'(SB_DEPTH));
  assign o_empty = (r_count == '0);

  always_comb begin
    o_overlap = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      o_overlap[i] = r_valid[i] && (r_mem[i].addr[SB_ADDR_W-1:3] == i_chk_dword);
    end
  end

`ifdef PIPELINE_MEMORY_SB_FWD_EN
  logic [PW-1:0] w_idx;
  logic [PW-1:0] w_young_idx;

  // Valid entries are contiguous from the read pointer, so the last hit in age order is the youngest.
  always_comb begin
    o_young_hit = 1'b0;
    w_young_idx = '0;
    w_idx       = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      w_idx = r_rd_ptr + PW'(k);
      if (o_overlap[w_idx]) begin
        o_young_hit = 1'b1;
        w_young_idx = w_idx;
      end
    end
  end

  assign o_young_entry = r_mem[w_young_idx];
`endif

endmodule

// File: rtl/pipeline_memory_sb.sv
// rtl/pipeline_memory_sb.sv - memory stage with background-draining store buffer
// Define PIPELINE_MEMORY_SB_FWD_EN for exact-match store-to-load forwarding.
module pipeline_memory_sb
  import pipeline_memory_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 64,
  parameter int SB_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  ready,
  input  logic [ADDR_WIDTH-1:0] ex_res,
  input  logic [DATA_WIDTH-1:0] r2_val,
  input  logic [4:0]            dst_reg,
  input  logic [6:0]            opcode,
  input  logic [3:0]            mem_operation_size,
  input  logic                  ecall,
  output logic                  wb_enable,
  output logic [4:0]            wb_dst_reg,
  output logic [DATA_WIDTH-1:0] wb_dst_val,
  output logic                  ecall_wb,
  output logic                  pending_write,
  output logic [ADDR_WIDTH-1:0] pending_write_addr,
  output logic [DATA_WIDTH-1:0] pending_write_data,
  output logic [1:0]            pending_write_size,
  output logic [ADDR_WIDTH-1:0] S_R_ADDR,
  output logic                  S_R_ADDR_VALID,
  input  logic [DATA_WIDTH-1:0] S_R_DATA,
  input  logic                  S_R_DATA_VALID,
  output logic                  S_W_VALID,
  output logic [ADDR_WIDTH-1:0] S_W_ADDR,
  output logic [DATA_WIDTH-1:0] S_W_DATA,
  output logic [3:0]            S_W_SIZE,
  input  logic                  S_W_READY,
  input  logic                  S_W_COMPLETE
);

  front_state_e        r_fstate, w_fnext;
  drain_state_e        r_dstate, w_dnext;
  logic [ADDR_WIDTH-1:0] r_ld_addr;
  logic [3:0]          r_ld_size;
  logic [4:0]          r_ld_dst;

  sb_entry_t           w_push_entry;
  sb_entry_t           w_head;
  logic                w_full, w_empty;
  logic [SB_DEPTH-1:0] w_overlap;
  logic                w_accept, w_push, w_pop, w_fwd, w_ld_issue;

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.addr = SB_ADDR_W'(ex_res);
    w_push_entry.data = SB_DATA_W'(r2_val);
    w_push_entry.size = size_width(mem_operation_size);
  end

`ifdef PIPELINE_MEMORY_SB_FWD_EN
  logic      w_young_hit;
  sb_entry_t w_young_entry;
  logic      w_young_fwd_ok;
  assign w_young_fwd_ok = w_young_hit && (w_young_entry.addr == w_push_entry.addr)
                          && (w_young_entry.size == w_push_entry.size);
`endif

  mem_store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_push_entry),
    .i_pop        (w_pop),
    .i_chk_dword  (w_push_entry.addr[SB_ADDR_W-1:3]),
`ifdef PIPELINE_MEMORY_SB_FWD_EN
    .o_young_hit  (w_young_hit),
    .o_young_entry(w_young_entry),
`endif
    .o_head       (w_head),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_overlap    (w_overlap)
  );

  // Front FSM: state register, next state, outputs.
  always_ff @(posedge clk) begin
    if (reset) r_fstate <= F_IDLE;
    else       r_fstate <= w_fnext;
  end

  always_comb begin
    w_fnext = r_fstate;
    case (r_fstate)
      F_IDLE, F_LD_RESP: w_fnext = w_ld_issue ? F_LD_REQ : F_IDLE;
      F_LD_REQ:          if (S_R_DATA_VALID) w_fnext = F_LD_RESP;
      default:           w_fnext = F_IDLE;
    endcase
  end

  // F_LD_RESP is the writeback cycle of a load and accepts new work exactly like F_IDLE.
  always_comb begin
    ready          = 1'b0;
    w_fwd          = 1'b0;
    S_R_ADDR_VALID = (r_fstate == F_LD_REQ);
    S_R_ADDR       = S_R_ADDR_VALID ? r_ld_addr : '0;
    if (!reset && r_fstate != F_LD_REQ) begin
      case (opcode)
        OP_NONE, OP_ALU: ready = 1'b1;
        OP_STORE:        ready = !w_full;
        OP_LOAD: begin
          ready = !(|w_overlap);
`ifdef PIPELINE_MEMORY_SB_FWD_EN
          if ((|w_overlap) && w_young_fwd_ok) begin
            ready = 1'b1;
            w_fwd = 1'b1;
          end
`endif
        end
        default:         ready = w_empty && (r_dstate == D_IDLE);
      endcase
    end
  end

  assign w_accept   = in_valid && ready;
  assign w_push     = w_accept && (opcode == OP_STORE);
  assign w_ld_issue = w_accept && (opcode == OP_LOAD) && !w_fwd;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_addr <= '0;
      r_ld_size <= '0;
      r_ld_dst  <= '0;
    end else if (w_ld_issue) begin
      r_ld_addr <= ex_res;
      r_ld_size <= mem_operation_size;
      r_ld_dst  <= dst_reg;
    end
  end

  // Drain FSM: state register, next state, outputs.
  always_ff @(posedge clk) begin
    if (reset) r_dstate <= D_IDLE;
    else       r_dstate <= w_dnext;
  end

  always_comb begin
    w_dnext = r_dstate;
    case (r_dstate)
      D_IDLE:  if (!w_empty) w_dnext = D_REQ;
      D_REQ:   if (S_W_READY) w_dnext = D_WAIT;
      D_WAIT:  if (S_W_COMPLETE) w_dnext = D_IDLE;
      default: w_dnext = D_IDLE;
    endcase
  end

  always_comb begin
    S_W_VALID = (r_dstate == D_REQ);
    S_W_ADDR  = S_W_VALID ? ADDR_WIDTH'(w_head.addr) : '0;
    S_W_DATA  = S_W_VALID ? DATA_WIDTH'(w_head.data) : '0;
    S_W_SIZE  = S_W_VALID ? {2'b00, w_head.size} : 4'd0;
    w_pop     = (r_dstate == D_WAIT) && S_W_COMPLETE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_enable          <= 1'b0;
      wb_dst_reg         <= '0;
      wb_dst_val         <= '0;
      ecall_wb           <= 1'b0;
      pending_write      <= 1'b0;
      pending_write_addr <= '0;
      pending_write_data <= '0;
      pending_write_size <= '0;
    end else begin
      wb_enable     <= 1'b0;
      ecall_wb      <= 1'b0;
      pending_write <= 1'b0;
      if (w_accept && opcode == OP_ALU) begin
        wb_enable  <= 1'b1;
        wb_dst_reg <= dst_reg;
        wb_dst_val <= DATA_WIDTH'(ex_res);
      end
`ifdef PIPELINE_MEMORY_SB_FWD_EN
      if (w_accept && opcode == OP_LOAD && w_fwd) begin
        wb_enable  <= 1'b1;
        wb_dst_reg <= dst_reg;
        wb_dst_val <= DATA_WIDTH'(extend_load(w_young_entry.data, mem_operation_size));
      end
`endif
      if (r_fstate == F_LD_REQ && S_R_DATA_VALID) begin
        wb_enable  <= 1'b1;
        wb_dst_reg <= r_ld_dst;
        wb_dst_val <= DATA_WIDTH'(extend_load(SB_DATA_W'(S_R_DATA), r_ld_size));
      end
      if (w_accept && opcode > 7'd3) ecall_wb <= ecall;
      if (w_pop) begin
        pending_write      <= 1'b1;
        pending_write_addr <= ADDR_WIDTH'(w_head.addr);
        pending_write_data <= DATA_WIDTH'(w_head.data);
        pending_write_size <= w_head.size;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_memory_sb.sv
// tb/tb_pipeline_memory_sb.sv - directed self-checking bench for pipeline_memory_sb
// Follows the forwarding path when PIPELINE_MEMORY_SB_FWD_EN is defined.
module tb_pipeline_memory_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        ready;
  logic [63:0] ex_res;
  logic [63:0] r2_val;
  logic [4:0]  dst_reg;
  logic [6:0]  opcode;
  logic [3:0]  mem_operation_size;
  logic        ecall;
  logic        wb_enable;
  logic [4:0]  wb_dst_reg;
  logic [63:0] wb_dst_val;
  logic        ecall_wb;
  logic        pending_write;
  logic [63:0] pending_write_addr;
  logic [63:0] pending_write_data;
  logic [1:0]  pending_write_size;
  logic [63:0] S_R_ADDR;
  logic        S_R_ADDR_VALID;
  logic [63:0] S_R_DATA;
  logic        S_R_DATA_VALID;
  logic        S_W_VALID;
  logic [63:0] S_W_ADDR;
  logic [63:0] S_W_DATA;
  logic [3:0]  S_W_SIZE;
  logic        S_W_READY;
  logic        S_W_COMPLETE;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] t_addr [8];
  logic [3:0]  t_size [8];
  logic [63:0] t_rdat [8];
  logic [63:0] t_exp  [8];

  always #5 clk = ~clk;

  pipeline_memory_sb dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .ready(ready),
    .ex_res(ex_res), .r2_val(r2_val), .dst_reg(dst_reg), .opcode(opcode),
    .mem_operation_size(mem_operation_size), .ecall(ecall),
    .wb_enable(wb_enable), .wb_dst_reg(wb_dst_reg), .wb_dst_val(wb_dst_val),
    .ecall_wb(ecall_wb), .pending_write(pending_write),
    .pending_write_addr(pending_write_addr), .pending_write_data(pending_write_data),
    .pending_write_size(pending_write_size),
    .S_R_ADDR(S_R_ADDR), .S_R_ADDR_VALID(S_R_ADDR_VALID), .S_R_DATA(S_R_DATA),
    .S_R_DATA_VALID(S_R_DATA_VALID), .S_W_VALID(S_W_VALID), .S_W_ADDR(S_W_ADDR),
    .S_W_DATA(S_W_DATA), .S_W_SIZE(S_W_SIZE), .S_W_READY(S_W_READY),
    .S_W_COMPLETE(S_W_COMPLETE)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic drive(input logic [6:0] op, input logic [63:0] addr, input logic [63:0] data,
                       input logic [3:0] sz, input logic [4:0] dst, input logic ec);
    in_valid = 1'b1; opcode = op; ex_res = addr; r2_val = data;
    mem_operation_size = sz; dst_reg = dst; ecall = ec;
  endtask

  task automatic idle();
    in_valid = 1'b0; opcode = 7'd0; ecall = 1'b0;
  endtask

  task automatic drain_one(input logic [63:0] a, input logic [63:0] d, input logic [3:0] sz);
    for (int k = 0; k < 20 && S_W_VALID !== 1'b1; k++) cyc();
    check("drain_valid", S_W_VALID, 1);
    check("drain_addr", S_W_ADDR, a);
    check("drain_data", S_W_DATA, d);
    check("drain_size", S_W_SIZE, sz);
    S_W_READY = 1'b1;
    cyc();
    S_W_READY = 1'b0;
    S_W_COMPLETE = 1'b1;
    cyc();
    S_W_COMPLETE = 1'b0;
    #1;
    check("pw_pulse", pending_write, 1);
    check("pw_addr", pending_write_addr, a);
    check("pw_size", pending_write_size, sz & 4'd3);
  endtask

  task automatic do_load(input string tag, input logic [63:0] addr, input logic [3:0] sz,
                         input logic [4:0] dst, input int lat, input logic [63:0] rdata,
                         input logic [63:0] exp);
    drive(7'd1, addr, 64'd0, sz, dst, 1'b0);
    #1 check("ld_ready", ready, 1);
    cyc();
    idle();
    #1;
    check("ld_req_valid", S_R_ADDR_VALID, 1);
    check("ld_req_addr", S_R_ADDR, addr);
    repeat (lat - 1) cyc();
    check("ld_req_held", S_R_ADDR_VALID, 1);
    S_R_DATA = rdata;
    S_R_DATA_VALID = 1'b1;
    cyc();
    S_R_DATA_VALID = 1'b0;
    #1;
    check("ld_wb_en", wb_enable, 1);
    check(tag, wb_dst_val, exp);
    check("ld_wb_dst", wb_dst_reg, dst);
    check("ld_ready_again", ready, 1);
    cyc();
    check("ld_wb_pulse_end", wb_enable, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    t_addr = '{64'h100, 64'h100, 64'h108, 64'h108, 64'h110, 64'h110, 64'h118, 64'h118};
    t_size = '{4'd0, 4'd4, 4'd1, 4'd6, 4'd2, 4'd5, 4'd3, 4'd9};
    t_rdat = '{64'h80, 64'h80, 64'h1234_8001, 64'h1234_8001,
               64'hFFFF_0000_8000_0000, 64'hFFFF_0000_8000_0000,
               64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};
    t_exp  = '{64'hFFFF_FFFF_FFFF_FF80, 64'h80, 64'hFFFF_FFFF_FFFF_8001, 64'h8001,
               64'hFFFF_FFFF_8000_0000, 64'h8000_0000,
               64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF};

    reset = 1'b1; idle(); ex_res = '0; r2_val = '0; dst_reg = '0; mem_operation_size = '0;
    S_R_DATA = '0; S_R_DATA_VALID = 1'b0; S_W_READY = 1'b0; S_W_COMPLETE = 1'b0;
    cyc(); cyc();
    check("rst_ready", ready, 0);
    check("rst_wb_en", wb_enable, 0);
    check("rst_sw_valid", S_W_VALID, 0);
    check("rst_sr_valid", S_R_ADDR_VALID, 0);
    check("rst_pw", pending_write, 0);
    check("rst_ecall_wb", ecall_wb, 0);
    reset = 1'b0;
    #1 check("post_rst_ready", ready, 1);

    // ALU writeback
    cyc();
    drive(7'd3, 64'h1234, 64'd0, 4'd0, 5'd5, 1'b0);
    #1 check("alu_ready", ready, 1);
    cyc();
    idle();
    #1;
    check("alu_wb_en", wb_enable, 1);
    check("alu_wb_val", wb_dst_val, 64'h1234);
    check("alu_wb_dst", wb_dst_reg, 5);
    check("alu_no_rd", S_R_ADDR_VALID, 0);
    check("alu_no_wr", S_W_VALID, 0);
    cyc();
    check("alu_pulse_end", wb_enable, 0);

    // Load extension table
    for (int i = 0; i < 8; i++)
      do_load($sformatf("ld_ext_%0d", i), t_addr[i], t_size[i], 5'(7 + i), 1 + (i % 3) + ((i == 0) ? 2 : 0),
              t_rdat[i], t_exp[i]);

    // Fill the buffer with the write port stalled
    for (int i = 0; i < 4; i++) begin
      drive(7'd2, 64'h1000 + 64'(8 * i), 64'(i), 4'd3, 5'd0, 1'b0);
      #1 check("sb_push_ready", ready, 1);
      cyc();
    end
    drive(7'd2, 64'h1020, 64'd4, 4'd3, 5'd0, 1'b0);
    #1 check("sb_full_ready", ready, 0);
    cyc(); cyc();
    check("sb_full_held", ready, 0);
    check("sb_head_valid", S_W_VALID, 1);
    check("sb_head_addr", S_W_ADDR, 64'h1000);
    S_W_READY = 1'b1;
    cyc();
    S_W_READY = 1'b0;
    S_W_COMPLETE = 1'b1;
    #1 check("sb_no_bypass", ready, 0);
    cyc();
    S_W_COMPLETE = 1'b0;
    #1;
    check("sb_pw_first", pending_write, 1);
    check("sb_pw_first_addr", pending_write_addr, 64'h1000);
    check("sb_ready_after_pop", ready, 1);
    cyc();
    idle();
    for (int i = 1; i < 5; i++) drain_one(64'h1000 + 64'(8 * i), 64'(i), 4'd3);

    // Store then load of the same dword
    cyc();
    drive(7'd2, 64'h200, 64'hDEAD, 4'd3, 5'd0, 1'b0);
    cyc();
    drive(7'd1, 64'h200, 64'd0, 4'd3, 5'd9, 1'b0);
`ifdef PIPELINE_MEMORY_SB_FWD_EN
    #1 check("fwd_ready", ready, 1);
    cyc();
    idle();
    #1;
    check("fwd_wb_en", wb_enable, 1);
    check("fwd_wb_val", wb_dst_val, 64'hDEAD);
    check("fwd_no_rd", S_R_ADDR_VALID, 0);
    cyc();
    check("fwd_no_rd_later", S_R_ADDR_VALID, 0);
    drain_one(64'h200, 64'hDEAD, 4'd3);
`else
    #1 check("conf_ready", ready, 0);
    repeat (3) begin
      cyc();
      check("conf_no_rd", S_R_ADDR_VALID, 0);
    end
    S_W_READY = 1'b1;
    cyc();
    S_W_READY = 1'b0;
    S_W_COMPLETE = 1'b1;
    #1 check("conf_stall_wait", ready, 0);
    cyc();
    S_W_COMPLETE = 1'b0;
    #1;
    check("conf_pw", pending_write, 1);
    check("conf_pw_addr", pending_write_addr, 64'h200);
    check("conf_rd_not_yet", S_R_ADDR_VALID, 0);
    check("conf_ready_free", ready, 1);
    cyc();
    idle();
    #1;
    check("conf_rd_valid", S_R_ADDR_VALID, 1);
    check("conf_rd_addr", S_R_ADDR, 64'h200);
    S_R_DATA = 64'hDEAD;
    S_R_DATA_VALID = 1'b1;
    cyc();
    S_R_DATA_VALID = 1'b0;
    #1;
    check("conf_wb_en", wb_enable, 1);
    check("conf_wb_val", wb_dst_val, 64'hDEAD);
    check("conf_wb_dst", wb_dst_reg, 9);
`endif

    // Read and drain concurrently on different dwords
    cyc();
    drive(7'd2, 64'h300, 64'h1122_3344, 4'd2, 5'd0, 1'b0);
    cyc();
    drive(7'd1, 64'h400, 64'd0, 4'd3, 5'd10, 1'b0);
    #1 check("conc_ready", ready, 1);
    cyc();
    idle();
    #1;
    check("conc_rd_valid", S_R_ADDR_VALID, 1);
    check("conc_wr_valid", S_W_VALID, 1);
    S_R_DATA = 64'hABCD;
    S_R_DATA_VALID = 1'b1;
    cyc();
    S_R_DATA_VALID = 1'b0;
    #1;
    check("conc_wb_val", wb_dst_val, 64'hABCD);
    check("conc_wb_dst", wb_dst_reg, 10);
    drain_one(64'h300, 64'h1122_3344, 4'd2);

    // ecall waits for the buffer to drain
    cyc();
    drive(7'd2, 64'h500, 64'h55, 4'd3, 5'd0, 1'b0);
    cyc();
    drive(7'd2, 64'h508, 64'h66, 4'd0, 5'd0, 1'b0);
    cyc();
    drive(7'h73, 64'd0, 64'd0, 4'd0, 5'd0, 1'b1);
    #1 check("ecall_stall", ready, 0);
    drain_one(64'h500, 64'h55, 4'd3);
    check("ecall_wait_wb", ecall_wb, 0);
    check("ecall_wait_ready", ready, 0);
    drain_one(64'h508, 64'h66, 4'd0);
    check("ecall_ready", ready, 1);
    check("ecall_not_yet", ecall_wb, 0);
    cyc();
    idle();
    #1 check("ecall_wb_pulse", ecall_wb, 1);
    cyc();
    check("ecall_wb_end", ecall_wb, 0);

    // Reset during D_WAIT and LD_REQ
    drive(7'd2, 64'h600, 64'h77, 4'd3, 5'd0, 1'b0);
    cyc();
    idle();
    cyc();
    check("rst2_dreq", S_W_VALID, 1);
    S_W_READY = 1'b1;
    cyc();
    S_W_READY = 1'b0;
    drive(7'd1, 64'h700, 64'd0, 4'd3, 5'd3, 1'b0);
    #1 check("rst2_ld_ready", ready, 1);
    cyc();
    idle();
    #1 check("rst2_rd_valid", S_R_ADDR_VALID, 1);
    reset = 1'b1;
    cyc();
    check("rst2_ready_in_reset", ready, 0);
    reset = 1'b0;
    #1;
    check("rst2_rd_drop", S_R_ADDR_VALID, 0);
    check("rst2_wr_drop", S_W_VALID, 0);
    check("rst2_ready", ready, 1);
    drive(7'h73, 64'd0, 64'd0, 4'd0, 5'd0, 1'b1);
    #1 check("rst2_empty", ready, 1);
    cyc();
    idle();
    #1 check("rst2_ecall_wb", ecall_wb, 1);
    repeat (3) cyc();
    check("rst2_no_drain", S_W_VALID, 0);
    check("rst2_no_pw", pending_write, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
